// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operand sequencer: FSM state encoding and defaults.
// No logic; imported by the debouncer and the top level.
// Button-select states mirror the one-hot select driven to the datapath.
package alu_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP1  = 2'd1;
  localparam logic [1:0] S_OP2  = 2'd2;

  localparam int DW_DEF        = 2;
  localparam int DB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF     = 3;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw push-button, debounces it and flags accepted rising levels.
// Latency: a stable raw rise shows as a one-cycle 'rise' DB_CYCLES+2 edges later.
// No backpressure; bounces shorter than DB_CYCLES synchronised cycles are dropped.
module btn_debounce
  import alu_seq_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             s1;
  logic             s2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser, stability counter, debounced level and registered edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        // s2 has disagreed with the debounced level for DB_CYCLES cycles in a row.
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front-end for the 2-bit add/sub datapath: debounced op select plus operand capture.
// Latency: stable raw button rise at edge t -> outputs and op_valid at edge t+DB_CYCLES+3.
// No backpressure; outputs hold between accepted presses, op_valid pulses once per press.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sw_a,
  input  logic [DW-1:0] sw_b,
  input  logic          sw_cin,
  input  logic          btn1_raw,
  input  logic          btn2_raw,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          cin_out,
  output logic          btn1_out,
  output logic          btn2_out,
  output logic          op_valid
);

  logic [1:0] state;
  logic       db1;
  logic       db2;
  logic       rise1;
  logic       rise2;
  logic       unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn1_raw),
    .level (db1),
    .rise  (rise1)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn2_raw),
    .level (db2),
    .rise  (rise2)
  );

  // Only the rising events matter here; the held levels are not needed downstream.
  assign unused_levels = db1 ^ db2;

  // Op-select FSM with operand capture; btn1 wins a same-cycle tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_out    <= '0;
      b_out    <= '0;
      cin_out  <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (rise1 || rise2) begin
        state    <= rise1 ? S_OP1 : S_OP2;
        a_out    <= sw_a;
        b_out    <= sw_b;
        cin_out  <= sw_cin;
        op_valid <= 1'b1;
      end
    end
  end

  // Decoding straight from the state keeps the select one-hot (or all-zero) by construction.
  assign btn1_out = (state == S_OP1);
  assign btn2_out = (state == S_OP2);

endmodule
